// File: rtl/mips16_pkg.sv
// Shared widths, forwarding encodings and the MEM/WB stage record for the
// 16-bit MIPS-style pipeline.
package mips16_pkg;

   localparam int DATA_W     = 16;
   localparam int REG_ADDR_W = 3;
   localparam int FWD_W      = 2;

   // EX operand source select
   localparam logic [FWD_W-1:0] FWD_REG      = 2'b00;
   localparam logic [FWD_W-1:0] FWD_MEM_ALU  = 2'b01;
   localparam logic [FWD_W-1:0] FWD_WB       = 2'b10;
   localparam logic [FWD_W-1:0] FWD_MEM_LOAD = 2'b11;

   // Contents of the WB pipeline register
   typedef struct packed {
      logic                  valid;
      logic                  reg_write;
      logic                  mem_to_reg;
      logic [REG_ADDR_W-1:0] write_reg;
      logic [DATA_W-1:0]     alu_result;
      logic [DATA_W-1:0]     read_data;
   } wb_stage_t;

endpackage

// File: rtl/forward_unit.sv
// Operand forwarding select for one EX source register. A producer in MEM
// is younger than one in WB, so MEM wins; r0 is hard-wired and never forwarded.
module forward_unit
   import mips16_pkg::*;
(
   input  logic [REG_ADDR_W-1:0] src,
   input  logic                  mem_valid,
   input  logic                  mem_reg_write,
   input  logic                  mem_mem_to_reg,
   input  logic [REG_ADDR_W-1:0] mem_write_reg,
   input  logic                  wb_reg_write,
   input  logic [REG_ADDR_W-1:0] wb_write_reg,
   output logic [FWD_W-1:0]      fwd
);

   // Priority select: MEM producer, then WB producer, else register file
   always_comb begin
      fwd = FWD_REG;
      if (src != '0) begin
         if (mem_valid && mem_reg_write && (mem_write_reg == src)) begin
            fwd = mem_mem_to_reg ? FWD_MEM_LOAD : FWD_MEM_ALU;
         end else if (wb_reg_write && (wb_write_reg == src)) begin
            fwd = FWD_WB;
         end
      end
   end

endmodule

// File: rtl/mem_wb.sv
// MEM->WB pipeline register with writeback mux, register-file write gating,
// EX operand forwarding and a saturating retired-instruction counter.
module mem_wb
   import mips16_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  mem_valid,
   input  logic [DATA_W-1:0]     mem_alu_result,
   input  logic [DATA_W-1:0]     read_data,
   input  logic                  mem_reg_write,
   input  logic                  mem_mem_to_reg,
   input  logic [REG_ADDR_W-1:0] mem_write_reg,
   input  logic                  stall,
   input  logic                  flush,
   input  logic [REG_ADDR_W-1:0] ex_rs,
   input  logic [REG_ADDR_W-1:0] ex_rt,
   output logic                  wb_reg_write,
   output logic [REG_ADDR_W-1:0] wb_write_reg,
   output logic [DATA_W-1:0]     wb_write_data,
   output logic [FWD_W-1:0]      fwd_a,
   output logic [FWD_W-1:0]      fwd_b,
   output logic [DATA_W-1:0]     fwd_data_mem,
   output logic [DATA_W-1:0]     retire_count
);

   wb_stage_t         wb_p1;
   logic [DATA_W-1:0] retire_cnt_p1;

   function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
      return (v == {DATA_W{1'b1}}) ? v : v + 1'b1;
   endfunction

   // ---- MEM -> WB boundary ----
   // Capture the MEM instruction, or insert a bubble when MEM is stalled or squashed
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wb_p1 <= '0;
      end else if (stall || flush) begin
         wb_p1.valid     <= 1'b0;
         wb_p1.reg_write <= 1'b0;
      end else begin
         wb_p1.valid      <= mem_valid;
         wb_p1.reg_write  <= mem_reg_write;
         wb_p1.mem_to_reg <= mem_mem_to_reg;
         wb_p1.write_reg  <= mem_write_reg;
         wb_p1.alu_result <= mem_alu_result;
         wb_p1.read_data  <= read_data;
      end
   end

   // Count every edge on which WB holds a real instruction, stopping at all-ones
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         retire_cnt_p1 <= '0;
      end else if (wb_p1.valid) begin
         retire_cnt_p1 <= sat_inc(retire_cnt_p1);
      end
   end

   assign wb_reg_write  = wb_p1.valid && wb_p1.reg_write && (wb_p1.write_reg != '0);
   assign wb_write_reg  = wb_p1.write_reg;
   assign wb_write_data = wb_p1.mem_to_reg ? wb_p1.read_data : wb_p1.alu_result;
   assign retire_count  = retire_cnt_p1;

   // A load's value is only on read_data late in the cycle; EX picks it via code 11
   assign fwd_data_mem  = mem_mem_to_reg ? read_data : mem_alu_result;

   forward_unit u_fwd_a (
      .src            (ex_rs),
      .mem_valid      (mem_valid),
      .mem_reg_write  (mem_reg_write),
      .mem_mem_to_reg (mem_mem_to_reg),
      .mem_write_reg  (mem_write_reg),
      .wb_reg_write   (wb_reg_write),
      .wb_write_reg   (wb_write_reg),
      .fwd            (fwd_a)
   );

   forward_unit u_fwd_b (
      .src            (ex_rt),
      .mem_valid      (mem_valid),
      .mem_reg_write  (mem_reg_write),
      .mem_mem_to_reg (mem_mem_to_reg),
      .mem_write_reg  (mem_write_reg),
      .wb_reg_write   (wb_reg_write),
      .wb_write_reg   (wb_write_reg),
      .fwd            (fwd_b)
   );

endmodule
